// File: rtl/axis_byte_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_byte_compactor: packs sparse-tkeep AXI4S beats into dense lines.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axis_byte_compactor #(
  parameter int DATA_BITS = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_BITS-1:0]     i_data_tdata,
  input  logic [DATA_BITS/8-1:0]   i_data_tkeep,
  input  logic                     i_data_tlast,
  input  logic                     i_data_tvalid,
  output logic                     i_data_tready,
  output logic [DATA_BITS-1:0]     o_data_tdata,
  output logic [DATA_BITS/8-1:0]   o_data_tkeep,
  output logic                     o_data_tlast,
  output logic                     o_data_tvalid,
  input  logic                     o_data_tready
);

  localparam int NB = DATA_BITS / 8;
  localparam int RW = $clog2(NB);
  localparam int TW = RW + 1;
  localparam logic [TW-1:0] NB_T = TW'(NB);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [DATA_BITS-1:0] res_q, res_d;
  logic [RW-1:0]        r_q, r_d;
  logic [DATA_BITS-1:0] tdata_q, tdata_d;
  logic [NB-1:0]        tkeep_q, tkeep_d;
  logic                 tlast_q, tlast_d;
  logic                 tvalid_q, tvalid_d;

  logic [2*DATA_BITS-1:0] w_comb;
  logic [TW-1:0]          w_total;
  logic                   w_slot_free;
  logic                   w_accept;

  function automatic logic [NB-1:0] low_mask(input logic [TW-1:0] cnt);
    logic [NB-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) m[k] = (k < int'(cnt));
    return m;
  endfunction

  // Residual bytes first, then the kept input bytes in ascending lane order.
  always_comb begin
    int idx;
    w_comb = '0;
    idx    = int'(r_q);
    for (int k = 0; k < NB; k++) begin
      if (k < int'(r_q)) w_comb[k*8 +: 8] = res_q[k*8 +: 8];
    end
    for (int j = 0; j < NB; j++) begin
      if (i_data_tkeep[j]) begin
        w_comb[idx*8 +: 8] = i_data_tdata[j*8 +: 8];
        idx = idx + 1;
      end
    end
    w_total = TW'(idx);
  end

  assign w_slot_free   = !tvalid_q || o_data_tready;
  assign i_data_tready = rst_n && (state_q == ST_ACCUM) && w_slot_free;
  assign w_accept      = i_data_tvalid && i_data_tready;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    r_d      = r_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q && !o_data_tready;
    if (state_q == ST_FLUSH) begin
      if (w_slot_free) begin
        tdata_d  = res_q;
        tkeep_d  = low_mask({1'b0, r_q});
        tlast_d  = 1'b1;
        tvalid_d = 1'b1;
        r_d      = '0;
        state_d  = ST_ACCUM;
      end
    end else if (w_accept) begin
      if (w_total >= NB_T) begin
        // Total is below 2*NB, so its low bits are exactly the overflow count.
        tdata_d  = w_comb[DATA_BITS-1:0];
        tkeep_d  = '1;
        tlast_d  = i_data_tlast && (w_total == NB_T);
        tvalid_d = 1'b1;
        res_d    = w_comb[2*DATA_BITS-1:DATA_BITS];
        r_d      = w_total[RW-1:0];
        if (i_data_tlast && (w_total != NB_T)) state_d = ST_FLUSH;
      end else if (i_data_tlast) begin
        tdata_d  = w_comb[DATA_BITS-1:0];
        tkeep_d  = low_mask(w_total);
        tlast_d  = 1'b1;
        tvalid_d = 1'b1;
        r_d      = '0;
      end else begin
        res_d = w_comb[DATA_BITS-1:0];
        r_d   = w_total[RW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ACCUM;
      res_q    <= '0;
      r_q      <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      r_q      <= r_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign o_data_tdata  = tdata_q;
  assign o_data_tkeep  = tkeep_q;
  assign o_data_tlast  = tlast_q;
  assign o_data_tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_byte_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axis_byte_compactor: directed vectors plus a byte-stream scoreboard.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axis_byte_compactor;

  localparam int DATA_BITS = 512;
  localparam int NB = DATA_BITS / 8;
  localparam logic [NB-1:0] K_ALL = '1;
  localparam logic [NB-1:0] K_HALF = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [NB-1:0] K40 = 64'h0000_00FF_FFFF_FFFF;
  localparam logic [NB-1:0] K20 = 64'h0000_0000_000F_FFFF;
  localparam logic [NB-1:0] K10 = 64'h0000_0000_0000_03FF;

  logic                 clk;
  logic                 rst_n;
  logic [DATA_BITS-1:0] i_tdata;
  logic [NB-1:0]        i_tkeep;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [DATA_BITS-1:0] o_tdata;
  logic [NB-1:0]        o_tkeep;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;

  axis_byte_compactor #(.DATA_BITS(DATA_BITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_data_tdata  (i_tdata),
    .i_data_tkeep  (i_tkeep),
    .i_data_tlast  (i_tlast),
    .i_data_tvalid (i_tvalid),
    .i_data_tready (i_tready),
    .o_data_tdata  (o_tdata),
    .o_data_tkeep  (o_tkeep),
    .o_data_tlast  (o_tlast),
    .o_data_tvalid (o_tvalid),
    .o_data_tready (o_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  task automatic rand_data();
    for (int w = 0; w < DATA_BITS / 32; w++) i_tdata[w*32 +: 32] = $urandom;
  endtask

  // Scoreboard: expected byte stream and per-packet byte counts.
  logic [7:0]           exp_q[$];
  int                   pkt_q[$];
  int                   in_cnt;
  int                   out_cnt;
  logic                 stall_prev;
  logic [DATA_BITS-1:0] prev_data;
  logic [NB-1:0]        prev_keep;
  logic                 prev_last;

  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_q.delete();
      pkt_q.delete();
      in_cnt     = 0;
      out_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", o_tvalid, 1);
        chk("stall_data", o_tdata === prev_data, 1);
        chk("stall_keep", o_tkeep, prev_keep);
        chk("stall_last", o_tlast, prev_last);
      end
      if (i_tvalid && i_tready) begin
        for (int j = 0; j < NB; j++) begin
          if (i_tkeep[j]) begin
            exp_q.push_back(i_tdata[j*8 +: 8]);
            in_cnt++;
          end
        end
        if (i_tlast) begin
          pkt_q.push_back(in_cnt);
          in_cnt = 0;
        end
      end
      if (o_tvalid && o_tready) begin
        logic [DATA_BITS-1:0] exp_d;
        logic [DATA_BITS-1:0] act_d;
        logic                 underflow;
        int                   exp_len;
        exp_d = '0;
        act_d = '0;
        underflow = 1'b0;
        chk("out_keep_contig", (o_tkeep & (o_tkeep + 1'b1)) == '0, 1);
        if (!o_tlast) chk("out_keep_full", o_tkeep, K_ALL);
        for (int b = 0; b < NB; b++) begin
          if (o_tkeep[b]) begin
            act_d[b*8 +: 8] = o_tdata[b*8 +: 8];
            out_cnt++;
            if (exp_q.size() == 0) underflow = 1'b1;
            else exp_d[b*8 +: 8] = exp_q.pop_front();
          end
        end
        chk("out_extra_bytes", underflow, 0);
        chk("out_data", act_d === exp_d, 1);
        if (o_tlast) begin
          exp_len = (pkt_q.size() > 0) ? pkt_q.pop_front() : -1;
          chk("out_pkt_len", out_cnt, exp_len);
          out_cnt = 0;
        end
      end
      stall_prev = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_keep  = o_tkeep;
      prev_last  = o_tlast;
    end
  end

  typedef struct {
    logic          v;
    logic [NB-1:0] keep;
    logic          last;
    logic          ordy;
    logic          exp_irdy;
    logic          exp_ov;
    logic [NB-1:0] exp_okeep;
    logic          exp_olast;
  } vec_t;

  localparam int NV = 18;
  vec_t vec[NV];

  initial begin
    bit abort;
    abort = 1'b0;
    vec[0]  = '{1'b1, K_ALL,  1'b0, 1'b1, 1'b1, 1'b1, K_ALL, 1'b0};
    vec[1]  = '{1'b1, K_ALL,  1'b0, 1'b1, 1'b1, 1'b1, K_ALL, 1'b0};
    vec[2]  = '{1'b1, K_ALL,  1'b1, 1'b1, 1'b1, 1'b1, K_ALL, 1'b1};
    vec[3]  = '{1'b1, K_HALF, 1'b0, 1'b1, 1'b1, 1'b0, '0,    1'b0};
    vec[4]  = '{1'b1, K_HALF, 1'b0, 1'b1, 1'b1, 1'b1, K_ALL, 1'b0};
    vec[5]  = '{1'b1, K_HALF, 1'b0, 1'b1, 1'b1, 1'b0, '0,    1'b0};
    vec[6]  = '{1'b1, K_HALF, 1'b1, 1'b1, 1'b1, 1'b1, K_ALL, 1'b1};
    vec[7]  = '{1'b1, K40,    1'b0, 1'b1, 1'b1, 1'b0, '0,    1'b0};
    vec[8]  = '{1'b1, K40,    1'b1, 1'b1, 1'b1, 1'b1, K_ALL, 1'b0};
    vec[9]  = '{1'b1, K_ALL,  1'b1, 1'b1, 1'b0, 1'b1, 64'hFFFF, 1'b1};
    vec[10] = '{1'b1, K_ALL,  1'b1, 1'b1, 1'b1, 1'b1, K_ALL, 1'b1};
    vec[11] = '{1'b1, K_ALL,  1'b0, 1'b1, 1'b1, 1'b1, K_ALL, 1'b0};
    vec[12] = '{1'b1, '0,     1'b1, 1'b1, 1'b1, 1'b1, '0,    1'b1};
    vec[13] = '{1'b1, K10,    1'b0, 1'b1, 1'b1, 1'b0, '0,    1'b0};
    vec[14] = '{1'b1, '0,     1'b1, 1'b1, 1'b1, 1'b1, K10,   1'b1};
    vec[15] = '{1'b1, K_ALL,  1'b1, 1'b0, 1'b0, 1'b1, K10,   1'b1};
    vec[16] = '{1'b1, K_ALL,  1'b1, 1'b1, 1'b1, 1'b1, K_ALL, 1'b1};
    vec[17] = '{1'b0, '0,     1'b0, 1'b1, 1'b1, 1'b0, '0,    1'b0};

    rst_n    = 1'b0;
    i_tvalid = 1'b0;
    i_tkeep  = '0;
    i_tlast  = 1'b0;
    i_tdata  = '0;
    o_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tready", i_tready, 0);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tkeep", o_tkeep, 0);
    chk("rst_tlast", o_tlast, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      i_tvalid = vec[i].v;
      i_tkeep  = vec[i].keep;
      i_tlast  = vec[i].last;
      o_tready = vec[i].ordy;
      rand_data();
      #1;
      chk($sformatf("v%0d_tready", i), i_tready, vec[i].exp_irdy);
      @(negedge clk);
      chk($sformatf("v%0d_tvalid", i), o_tvalid, vec[i].exp_ov);
      if (vec[i].exp_ov) begin
        chk($sformatf("v%0d_tkeep", i), o_tkeep, vec[i].exp_okeep);
        chk($sformatf("v%0d_tlast", i), o_tlast, vec[i].exp_olast);
      end
    end

    // Reset mid-packet: residual of 20 bytes and a stalled full beat pending.
    i_tvalid = 1'b1; i_tkeep = K20; i_tlast = 1'b0; o_tready = 1'b1; rand_data();
    @(negedge clk);
    i_tkeep = K_ALL; rand_data();
    @(negedge clk);
    i_tvalid = 1'b0; o_tready = 1'b0;
    @(negedge clk);
    chk("rstmid_pending", o_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tready", i_tready, 0);
    @(negedge clk);
    chk("rstmid_tvalid", o_tvalid, 0);
    rst_n = 1'b1;
    i_tvalid = 1'b1; i_tkeep = K_ALL; i_tlast = 1'b1; o_tready = 1'b1; rand_data();
    @(negedge clk);
    chk("rstmid_out_valid", o_tvalid, 1);
    chk("rstmid_out_keep", o_tkeep, K_ALL);
    chk("rstmid_out_last", o_tlast, 1);
    i_tvalid = 1'b0;
    @(negedge clk);
    chk("rstmid_single", o_tvalid, 0);

    // Random tkeep packets under 50% output backpressure.
    for (int p = 0; p < 200 && !abort; p++) begin
      int nbeats;
      nbeats = $urandom_range(1, 4);
      for (int b = 0; b < nbeats && !abort; b++) begin
        int  guard;
        bit  acc;
        int  sel;
        sel = $urandom_range(0, 7);
        if (sel == 0)      i_tkeep = '0;
        else if (sel <= 2) i_tkeep = K_ALL;
        else               i_tkeep = {$urandom, $urandom};
        i_tlast  = (b == nbeats - 1);
        i_tvalid = 1'b1;
        rand_data();
        guard = 0;
        acc   = 1'b0;
        while (!acc) begin
          o_tready = 1'($urandom_range(0, 1));
          #1;
          acc = i_tready;
          @(negedge clk);
          guard++;
          if (!acc && guard > 100) begin
            chk("bp_accept_timeout", 0, 1);
            abort = 1'b1;
            break;
          end
        end
      end
    end
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain_bytes", exp_q.size(), 0);
    chk("drain_pkts", pkt_q.size(), 0);
    chk("drain_out_cnt", out_cnt, 0);
    chk("drain_idle", o_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_byte_compactor.md
# axis_byte_compactor

Downstream neighbour of the gzip wrapper. Sits between the gzip wrapper's output FIFO and the host write path. It removes holes from 512-bit AXI4S beats whose `tkeep` is sparse, because the compressor's 64-bit words are concatenated into lines without normalisation. It emits dense lines: every beat is fully kept except the final beat of a packet, whose kept bytes are a contiguous run starting at byte 0.

## Interface
Parameters:
- `DATA_BITS`, default `AXI_DATA_BITS` (512): stream width; `NB = DATA_BITS/8` bytes per beat.

Ports:
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `i_data`, `AXI4S.s`, DATA_BITS: input stream.
  - `tkeep` may have any byte pattern, including all-zero.
  - `tlast` marks the end of a packet.
- `o_data`, `AXI4S.m`, DATA_BITS: compacted output stream.

## Operation
Compaction of each accepted input beat:
- Kept bytes are packed in ascending byte order into `p[0..n-1]`, where `n = popcount(tkeep)`, range 0..NB.
- Packed bytes are appended after the residual buffer `res[0..r-1]`, where r is 0..NB-1.
- Total `t = r + n`, range 0..2·NB-1. Width is 7 bits for NB=64.

Decisions per accepted beat (state ACCUM):
- **t ≥ NB:** load the output register with combined bytes 0..NB-1 and `tkeep` all-ones.
  - New residual is the combined bytes NB..t-1, with `r ← t-NB`.
  - `tlast = i.tlast && t==NB`.
  - If `i.tlast && t>NB`, go to FLUSH.
- **t < NB and i.tlast:** load the output register with combined bytes, `tkeep = (1<<t)-1`, `tlast=1`, and set `r←0`.
  - When t==0, this is a `tkeep=0`, `tlast=1` beat. It preserves the packet boundary.
- **t < NB and !i.tlast:** no output; `res ← combined`, `r←t`.

FLUSH state:
- When the output slot is free, load the output register with `res`, `tkeep=(1<<r)-1`, `tlast=1`.
- Set `r←0` and return to ACCUM.
- No input is accepted while in FLUSH.

Data, ordering and packets:
- Data bytes are never reordered or dropped.
- Output byte count per packet equals the sum of input popcounts.
- Residual bytes never cross a packet boundary.

## Timing
- Output register `o_data.{tdata,tkeep,tlast,tvalid}`. `tvalid` is held until `o_data.tready`, and contents are stable while `tvalid && !tready`.
- "Slot free" means `!o_data.tvalid || o_data.tready`.
- `i_data.tready = (state==ACCUM) && slot_free`. This is combinational from `o_data.tready`.
- Latency: a beat accepted at cycle k that produces output has `o_data.tvalid=1` at cycle k+1.
- Throughput: 1 beat/cycle under continuous `o_data.tready`. The exception is one bubble cycle on input per packet whose last beat has t>NB, spent in FLUSH.
- Simultaneous output handshake and input accept in the same cycle: the old beat leaves and the new beat loads; `tvalid` stays 1.
- Accepted beat producing no output while the old beat is handshaken: `tvalid←0`.
- Reset (`rst_n=0` at a clk edge) values:
  - `o_data.tvalid=0`, `o_data.tlast=0`, `o_data.tkeep=0`, `r=0`, state ACCUM.
  - `i_data.tready=0` while `rst_n=0`.
- Reset mid-packet discards the residual and any pending output beat.

## Test plan
- **Dense passthrough:** 3 beats with `tkeep=all-ones`, last with tlast, `o_data.tready=1` → 3 identical beats one cycle later; last has `tkeep=all-ones`, `tlast=1`.
- **Half-lane holes:** 4 beats with `tkeep=0x0F0F…0F` (32 bytes each), tlast on 4th → 2 output beats with `tkeep=all-ones`, tlast on the second; bytes in input order.
- **Overflow tail:** beats with 40 bytes and then 40 bytes+tlast (t=80) → beat 1 is full with `tlast=0`; FLUSH beat has `tkeep=0xFFFF` (16 bytes), `tlast=1`; `i_data.tready=0` for exactly one cycle.
- **Empty last:** 64 bytes then `tkeep=0`+tlast → full beat with `tlast=0`, then `tkeep=0`, `tlast=1`. Separately, 10 bytes then `tkeep=0`+tlast → one beat with `tkeep=0x3FF`, `tlast=1`.
- **Backpressure:** random `o_data.tready` (50%) over 200 random-tkeep packets → output byte stream equals the packed reference model, outputs stable while stalled, no beat lost or duplicated.
- **Reset mid-packet:** assert `rst_n=0` for 1 cycle with r=20 and valid output pending → `tvalid=0` next cycle; the next packet of 64 bytes+tlast emits exactly one full beat with no stale bytes.
